// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } loaderState_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam logic [31:0] ADDR_STEP     = 32'd4;
    localparam logic [1:0]  LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes in big-endian order into a 32-bit word; full flags that the
// next push completes the word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [31:0] wordQ;
    logic [1:0]  idxQ;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wordQ <= '0;
            idxQ  <= '0;
        end else if (push) begin
            wordQ <= {wordQ[23:0], byte_in};
            idxQ  <= idxQ + 2'd1;
        end
    end

    assign word_out = wordQ;
    assign full     = (idxQ == LAST_BYTE_IDX);

endmodule

// File: rtl/inst_mem_loader.sv
// Fills INST_MEM from a byte stream, stalling the CPU during the load and
// restarting fetch from BASE_ADDR once the last word is written.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             pc_clear,
    output logic             done,
    output logic             error
);

    loaderState_e     stateQ, stateD;
    logic [31:0]      addrQ, addrD;
    logic [CNT_W-1:0] remainQ, remainD;
    logic             holdQ, errorQ, errorD;
    logic             push, packClr, lastByte;
    logic [31:0]      packedWord;

    byte_packer uPacker (
        .clk      (clk),
        .rst      (rst),
        .clr      (packClr),
        .push     (push),
        .byte_in  (in_data),
        .word_out (packedWord),
        .full     (lastByte)
    );

    assign push = in_valid & in_ready;

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        remainD = remainQ;
        errorD  = 1'b0;
        packClr = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    if (word_count == '0) begin
                        stateD = StDone;
                    end else if (word_count > CNT_W'(MAX_WORDS)) begin
                        errorD = 1'b1;
                    end else begin
                        stateD  = StLoad;
                        remainD = word_count;
                        addrD   = BASE_ADDR;
                        packClr = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (abort) begin
                    stateD  = StIdle;
                    addrD   = BASE_ADDR;
                    packClr = 1'b1;
                end else if (push && lastByte) begin
                    stateD = StWrite;
                end
            end
            StWrite: begin
                // The write itself happens this cycle regardless of abort.
                if (abort) begin
                    stateD  = StIdle;
                    addrD   = BASE_ADDR;
                    packClr = 1'b1;
                end else begin
                    addrD   = addrQ + ADDR_STEP;
                    remainD = remainQ - CNT_W'(1);
                    stateD  = (remainQ == CNT_W'(1)) ? StDone : StLoad;
                end
            end
            StDone: begin
                stateD = StIdle;
                addrD  = BASE_ADDR;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            addrQ   <= BASE_ADDR;
            remainQ <= '0;
            holdQ   <= 1'b0;
            errorQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            remainQ <= remainD;
            holdQ   <= (stateD != StIdle);
            errorQ  <= errorD;
        end
    end

    assign in_ready  = (stateQ == StLoad);
    assign mem_we    = (stateQ == StWrite);
    assign mem_addr  = addrQ;
    assign mem_wdata = packedWord;
    assign cpu_hold  = holdQ;
    assign done      = (stateQ == StDone);
    assign pc_clear  = (stateQ == StDone);
    assign error     = errorQ;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised self-checking bench for inst_mem_loader against a per-load
// reference of the byte stream, expected writes and handshake timing.
module tb_inst_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    logic        clk = 1'b0;
    logic        rst, start, abort, in_valid;
    logic [8:0]  word_count;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, pc_clear, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int nCmp = 0;
    int nErr = 0;
    logic [7:0] srcBytes[$];

    always #5 clk = ~clk;

    inst_mem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .CNT_W     (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .pc_clear   (pc_clear),
        .done       (done),
        .error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input bit wdataZero);
        @(negedge clk);
        chk({tag, ".ready"}, in_ready, 0);
        chk({tag, ".we"}, mem_we, 0);
        chk({tag, ".hold"}, cpu_hold, 0);
        chk({tag, ".pcClr"}, pc_clear, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".error"}, error, 0);
        chk({tag, ".addr"}, mem_addr, BASE);
        if (wdataZero) chk({tag, ".wdata"}, mem_wdata, 0);
        step();
    endtask

    task automatic fillRandom(input int n);
        srcBytes.delete();
        for (int i = 0; i < 4 * n; i++) srcBytes.push_back(8'($urandom));
    endtask

    // abortAt: accepted-byte count at which abort is pulsed (-1 = never).
    // glitchCyc: load cycle in which a stray start is pulsed (-1 = never).
    task automatic runLoad(input int n, input int gapPct, input int abortAt,
                           input int glitchCyc, input bit rstInWrite);
        int acc = 0;
        int wr = 0;
        int cyc = 0;
        bit wantWe = 0, wantDone = 0, finished = 0, stopped = 0;
        bit accept, doAbort, doRst;
        logic [31:0] expW;
        start = 1'b1;
        word_count = 9'(n);
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("startCycle.hold", cpu_hold, 0);
        chk("startCycle.ready", in_ready, 0);
        step();
        while (!finished && !stopped && cyc < 2000) begin
            doAbort = (abortAt >= 0) && (acc == abortAt) && !wantWe && !wantDone;
            doRst = rstInWrite && wantWe;
            rst = doRst;
            abort = doAbort;
            start = (cyc == glitchCyc);
            word_count = start ? 9'd1 : 9'($urandom_range(0, 511));
            in_valid = !doAbort && !doRst && (acc < 4 * n) && ($urandom_range(0, 99) >= gapPct);
            in_data = in_valid ? srcBytes[acc] : 8'($urandom);
            @(negedge clk);
            chk("hold", cpu_hold, 1);
            chk("ready", in_ready, 32'(!wantWe && !wantDone));
            chk("we", mem_we, 32'(wantWe));
            chk("done", done, 32'(wantDone));
            chk("pcClr", pc_clear, 32'(wantDone));
            accept = in_valid && !wantWe && !wantDone;
            if (wantWe) begin
                expW = {srcBytes[4*wr], srcBytes[4*wr+1], srcBytes[4*wr+2], srcBytes[4*wr+3]};
                chk("addr", mem_addr, BASE + 32'(4 * wr));
                chk("wdata", mem_wdata, expW);
                wr++;
            end
            finished = wantDone;
            stopped = doAbort || doRst;
            wantDone = wantWe && (wr == n) && !doAbort;
            wantWe = accept && (((acc + 1) % 4) == 0);
            if (accept) acc++;
            cyc++;
            step();
        end
        if (cyc >= 2000) chk("timeout", 1, 0);
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        checkIdle("after", rstInWrite);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        word_count = 9'd0;
        step();
        step();
        checkIdle("reset", 1'b1);
        rst = 1'b0;

        srcBytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
        runLoad(2, 0, -1, -1, 1'b0);
        runLoad(2, 40, -1, -1, 1'b0);

        // Zero-length load: done next cycle, no writes.
        start = 1'b1;
        word_count = 9'd0;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("zero.done", done, 1);
        chk("zero.pcClr", pc_clear, 1);
        chk("zero.hold", cpu_hold, 1);
        chk("zero.we", mem_we, 0);
        step();
        checkIdle("zeroAfter", 1'b0);

        // Oversized request: error pulse, stays idle.
        start = 1'b1;
        word_count = 9'd257;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("err.error", error, 1);
        chk("err.hold", cpu_hold, 0);
        chk("err.ready", in_ready, 0);
        step();
        checkIdle("errAfter", 1'b0);

        fillRandom(3);
        runLoad(3, 0, 2, -1, 1'b0);
        fillRandom(2);
        runLoad(2, 20, -1, -1, 1'b0);

        fillRandom(2);
        runLoad(2, 0, -1, -1, 1'b1);

        fillRandom(3);
        runLoad(3, 10, -1, 2, 1'b0);

        for (int it = 0; it < 12; it++) begin
            int n = $urandom_range(1, 6);
            int ab = ($urandom_range(0, 3) == 0) ? 2 * $urandom_range(0, 2 * n - 1) + 1 : -1;
            fillRandom(n);
            runLoad(n, $urandom_range(0, 60), ab, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
